cart_probe_array: RTL and testbench

//  Parametrised cartridge-bus timing probe. Sits behind the registered SB_IO pad samples of the GB cart bus.

---
 rtl/cart_probe_array_pkg.sv | 31 +++
 rtl/cart_probe_array_channel.sv | 122 ++++++++++++
 rtl/cart_probe_array.sv | 230 +++++++++++++++++++++++
 tb/tb_cart_probe_array.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_probe_array_pkg.sv
// Shared definitions for the cartridge-bus timing probe.
//   - Register offsets inside a 4-byte probe channel window.
//   - Bit positions inside the channel status byte.
//   - Decoded-address record used by the top-level decoder.
//   - ROM image generator (fixed pattern served on all non-probe addresses).
package cart_probe_array_pkg;

  // Register offsets within one channel window
  localparam logic [1:0] OFS_ARM  = 2'd0;
  localparam logic [1:0] OFS_THR  = 2'd1;
  localparam logic [1:0] OFS_SNAP = 2'd2;
  localparam logic [1:0] OFS_STAT = 2'd3;

  // Status byte bit indices
  localparam int ST_ARMED      = 0;
  localparam int ST_SAT        = 1;
  localparam int ST_SNAP_VALID = 2;

  // Result of decoding one bus address against the probe window
  typedef struct packed {
    logic       hit;  // address falls inside a populated channel window
    logic [3:0] ch;   // channel index
    logic [1:0] ofs;  // register offset inside the channel
  } probe_dec_t;

  // ROM image content: a fixed byte pattern indexed by the low address bits
  function automatic logic [7:0] rom_word(input logic [7:0] idx);
    rom_word = (idx * 8'd37) ^ 8'h5A;
  endfunction

endpackage

// File: rtl/cart_probe_array_channel.sv
// One probe channel: cycle counter, threshold, snapshot and status flags.
// Ports:
//   clk, n_reset   clock and asynchronous active-low reset
//   arm_hold       write strobe currently targets the arm register (counter forced to 0)
//   arm            committed write to the arm register (restart measurement)
//   disarm         committed write to status with bit0 = 0 (freeze counter)
//   thr_wr         committed write to the threshold register
//   wr_data        committed write data (threshold value)
//   rd_edge        first clk of a CPU read of the arm register (snapshot request)
//   rd_ofs         register offset being read
//   cmp            counter strictly above threshold
//   rd_data        read mux for threshold / snapshot / status (arm offset reads 0 here)
//   snap           current snapshot value
//   stat           low status nibble {0, snap_valid, sat, armed}
module cart_probe_array_channel
  import cart_probe_array_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DATA_W  = 8,
  parameter int THR_RST = 'h10
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              arm_hold,
  input  logic              arm,
  input  logic              disarm,
  input  logic              thr_wr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic              rd_edge,
  input  logic [1:0]        rd_ofs,
  output logic              cmp,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  snap,
  output logic [3:0]        stat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] thr_r;
  logic [CNT_W-1:0] snap_r;
  logic             armed_r;
  logic             sat_r;
  logic             snap_valid_r;

  // Counter, armed and saturation flags. The count still advances on the
  // disarm edge itself, so the frozen value includes that last clk.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r   <= CNT_W'(0);
      armed_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (arm) begin
      cnt_r   <= CNT_W'(0);
      armed_r <= 1'b1;
      sat_r   <= 1'b0;
    end else begin
      if (disarm) begin
        armed_r <= 1'b0;
      end
      if (arm_hold) begin
        cnt_r <= CNT_W'(0);
      end else if (armed_r) begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_W'(1);
          // flag saturation in the same clk the counter reaches all-ones
          if (cnt_r == (CNT_MAX - CNT_W'(1))) begin
            sat_r <= 1'b1;
          end
        end else begin
          sat_r <= 1'b1;
        end
      end
    end
  end

  // Threshold register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      thr_r <= CNT_W'(THR_RST);
    end else if (thr_wr) begin
      thr_r <= wr_data;
    end
  end

  // Snapshot: first read of the arm register after arming latches the count
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      snap_r       <= CNT_W'(0);
      snap_valid_r <= 1'b0;
    end else if (arm) begin
      snap_r       <= CNT_W'(0);
      snap_valid_r <= 1'b0;
    end else if (rd_edge && armed_r && !snap_valid_r) begin
      snap_r       <= cnt_r;
      snap_valid_r <= 1'b1;
    end
  end

  assign cmp  = (cnt_r > thr_r);
  assign snap = snap_r;

  // Status nibble assembly
  always_comb begin
    stat                = 4'b0000;
    stat[ST_ARMED]      = armed_r;
    stat[ST_SAT]        = sat_r;
    stat[ST_SNAP_VALID] = snap_valid_r;
  end

  // Register read mux; the compare byte for the arm offset is formed at the top
  always_comb begin
    rd_data = DATA_W'(0);
    case (rd_ofs)
      OFS_THR:  rd_data = DATA_W'(thr_r);
      OFS_SNAP: rd_data = DATA_W'(snap_r);
      OFS_STAT: rd_data = DATA_W'(stat);
      default:  rd_data = DATA_W'(0);
    endcase
  end

endmodule

// File: rtl/cart_probe_array.sv
// Cartridge-bus timing probe top level.
// Serves a ROM image on the GB cart bus and exposes CHANNELS probe windows
// that measure clk cycles between an arming write and a later CPU read.
// Ports:
//   clk       PLL clock, all bus samples synchronous to it
//   n_reset   asynchronous active-low reset
//   adr_in    registered address sample (A14..A0)
//   data_in   registered data sample
//   nrd, nwr  registered read / write strobes, active low
//   ncs       registered chip select (A15), active low
//   data_out  value for the data pad output register (2 clk after adr_in)
//   data_drv  data pad output enable / bdir
//   led       {status nibble of last channel, last channel, snapshot of channel 0}
//   chan      index of the last channel touched
module cart_probe_array
  import cart_probe_array_pkg::*;
#(
  parameter int ADR_W      = 15,
  parameter int DATA_W     = 8,
  parameter int ROM_AW     = 7,
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 8,
  parameter int PROBE_BASE = 'h00F0,
  parameter int THR_RST    = 'h10
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADR_W-1:0]  adr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              nrd,
  input  logic              nwr,
  input  logic              ncs,
  output logic [DATA_W-1:0] data_out,
  output logic              data_drv,
  output logic [15:0]       led,
  output logic [3:0]        chan
);

  localparam logic [ADR_W-1:0] PBASE = ADR_W'(PROBE_BASE);
  localparam logic [ADR_W-1:0] NWIN  = ADR_W'(4 * CHANNELS);

  // Map an address onto (hit, channel, offset); unpopulated window slots miss
  function automatic probe_dec_t decode(input logic [ADR_W-1:0] a);
    probe_dec_t       d;
    logic [ADR_W-1:0] off;
    off   = a - PBASE;
    d.hit = (a >= PBASE) && (off < NWIN);
    d.ch  = off[5:2];
    d.ofs = off[1:0];
    return d;
  endfunction

  logic              ws_s;
  logic              ws_d_r;
  logic              commit_s;
  logic              rd_act_s;
  logic [ADR_W-1:0]  hold_adr_r;
  logic [DATA_W-1:0] hold_data_r;
  probe_dec_t        wr_dec_s;
  probe_dec_t        in_dec_s;

  logic [CHANNELS-1:0] arm_v;
  logic [CHANNELS-1:0] hold_v;
  logic [CHANNELS-1:0] disarm_v;
  logic [CHANNELS-1:0] thr_wr_v;
  logic [CHANNELS-1:0] rd_sel_v;
  logic [CHANNELS-1:0] rd_sel_d_r;
  logic [CHANNELS-1:0] rd_edge_v;
  logic [CHANNELS-1:0] ch_cmp_s;

  logic [DATA_W-1:0] ch_rd_s   [CHANNELS];
  logic [CNT_W-1:0]  ch_snap_s [CHANNELS];
  logic [3:0]        ch_stat_s [CHANNELS];

  logic [DATA_W-1:0] probe_mux_s;
  logic [3:0]        led_stat_s;
  logic              sel_probe_r;
  logic [DATA_W-1:0] probe_q_r;
  logic [DATA_W-1:0] rom_q_r;
  logic [DATA_W-1:0] data_out_r;
  logic [3:0]        chan_r;
  logic [15:0]       led_r;

  assign ws_s     = !nwr && !ncs;
  assign rd_act_s = !nrd && !ncs;
  // a write is acted on only once the strobe has ended
  assign commit_s = ws_d_r && !ws_s;
  // read while writing: the write wins and the pad stays an input
  assign data_drv = !nrd && nwr && !ncs;

  assign wr_dec_s = decode(hold_adr_r);
  assign in_dec_s = decode(adr_in);

  // Write strobe tracking: keep the last address/data seen during the strobe
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ws_d_r      <= 1'b0;
      hold_adr_r  <= ADR_W'(0);
      hold_data_r <= DATA_W'(0);
    end else begin
      ws_d_r <= ws_s;
      if (ws_s) begin
        hold_adr_r  <= adr_in;
        hold_data_r <= data_in;
      end
    end
  end

  // Per-channel write and read strobes
  always_comb begin
    arm_v    = '0;
    hold_v   = '0;
    disarm_v = '0;
    thr_wr_v = '0;
    rd_sel_v = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      arm_v[c]    = commit_s && wr_dec_s.hit && (wr_dec_s.ch == 4'(c)) && (wr_dec_s.ofs == OFS_ARM);
      thr_wr_v[c] = commit_s && wr_dec_s.hit && (wr_dec_s.ch == 4'(c)) && (wr_dec_s.ofs == OFS_THR);
      disarm_v[c] = commit_s && wr_dec_s.hit && (wr_dec_s.ch == 4'(c)) && (wr_dec_s.ofs == OFS_STAT)
                    && !hold_data_r[0];
      hold_v[c]   = ws_s && in_dec_s.hit && (in_dec_s.ch == 4'(c)) && (in_dec_s.ofs == OFS_ARM);
      rd_sel_v[c] = rd_act_s && in_dec_s.hit && (in_dec_s.ch == 4'(c)) && (in_dec_s.ofs == OFS_ARM);
    end
  end

  // Read-select history for snapshot edge detection
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_sel_d_r <= '0;
    end else begin
      rd_sel_d_r <= rd_sel_v;
    end
  end

  assign rd_edge_v = rd_sel_v & ~rd_sel_d_r;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_chan
    cart_probe_array_channel #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W),
      .THR_RST(THR_RST)
    ) u_chan (
      .clk     (clk),
      .n_reset (n_reset),
      .arm_hold(hold_v[g]),
      .arm     (arm_v[g]),
      .disarm  (disarm_v[g]),
      .thr_wr  (thr_wr_v[g]),
      .wr_data (CNT_W'(hold_data_r)),
      .rd_edge (rd_edge_v[g]),
      .rd_ofs  (in_dec_s.ofs),
      .cmp     (ch_cmp_s[g]),
      .rd_data (ch_rd_s[g]),
      .snap    (ch_snap_s[g]),
      .stat    (ch_stat_s[g])
    );
  end

  // Select the addressed channel's read value; the arm offset returns the compare byte
  always_comb begin
    probe_mux_s = DATA_W'(0);
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_dec_s.ch == 4'(c)) begin
        probe_mux_s = (in_dec_s.ofs == OFS_ARM) ? {DATA_W{ch_cmp_s[c]}} : ch_rd_s[c];
      end else begin
        probe_mux_s = probe_mux_s;
      end
    end
  end

  // Status nibble of the last touched channel for the debug LEDs
  always_comb begin
    led_stat_s = 4'b0000;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_r == 4'(c)) begin
        led_stat_s = ch_stat_s[c];
      end else begin
        led_stat_s = led_stat_s;
      end
    end
  end

  // Read pipeline stage 1: registered ROM lookup and registered probe mux
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sel_probe_r <= 1'b0;
      probe_q_r   <= DATA_W'(0);
      rom_q_r     <= DATA_W'(0);
    end else begin
      sel_probe_r <= in_dec_s.hit;
      probe_q_r   <= probe_mux_s;
      rom_q_r     <= DATA_W'(rom_word(8'(adr_in[ROM_AW-1:0])));
    end
  end

  // Read pipeline stage 2: data pad output register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      data_out_r <= DATA_W'(0);
    end else begin
      data_out_r <= sel_probe_r ? probe_q_r : rom_q_r;
    end
  end

  // Last channel touched by a committed write or an active read
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      chan_r <= 4'd0;
    end else if (commit_s && wr_dec_s.hit) begin
      chan_r <= wr_dec_s.ch;
    end else if (rd_act_s && in_dec_s.hit) begin
      chan_r <= in_dec_s.ch;
    end
  end

  // Debug LED register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      led_r <= 16'h0000;
    end else begin
      led_r <= {led_stat_s, chan_r, 8'(ch_snap_s[0])};
    end
  end

  assign data_out = data_out_r;
  assign led      = led_r;
  assign chan     = chan_r;

endmodule

// File: tb/tb_cart_probe_array.sv
// Self-checking bench for cart_probe_array: directed scenarios followed by
// random bus traffic, checked against a time-based reference model.
module tb_cart_probe_array;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [14:0] adr_in;
  logic [7:0]  data_in;
  logic        nrd, nwr, ncs;
  logic [7:0]  data_out;
  logic        data_drv;
  logic [15:0] led;
  logic [3:0]  chan;

  cart_probe_array dut (
    .clk     (clk),
    .n_reset (n_reset),
    .adr_in  (adr_in),
    .data_in (data_in),
    .nrd     (nrd),
    .nwr     (nwr),
    .ncs     (ncs),
    .data_out(data_out),
    .data_drv(data_drv),
    .led     (led),
    .chan    (chan)
  );

  always #5 clk = ~clk;

  // Edge counter: after "@(posedge clk); #1" it holds the index of that edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel is described by when it was armed, not by a counter
  int rom_m   [128];
  int m_thr   [4];
  int m_e0    [4];   // edge index of the arming commit
  int m_fz    [4];   // counter value frozen by a disarm
  int m_snap  [4];
  bit m_armed [4];
  bit m_sv    [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_thr[c] = 'h10; m_e0[c] = 0; m_fz[c] = 0; m_snap[c] = 0;
      m_armed[c] = 1'b0; m_sv[c] = 1'b0;
    end
  endtask

  // Count a channel would show at edge index t (elapsed edges since arming, clamped)
  function automatic int elapsed(int c, int t);
    int v;
    v = t - m_e0[c];
    return (v > 255) ? 255 : v;
  endfunction

  // Counter value seen by a read issued now
  function automatic int cval(int c);
    return m_armed[c] ? elapsed(c, cyc) : m_fz[c];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic bus_write(input logic [14:0] adr, input logic [7:0] d, input int n);
    int c, o, e;
    adr_in = adr; data_in = d; nrd = 1'b1; nwr = 1'b0; ncs = 1'b0;
    repeat (n) step();
    nwr = 1'b1; ncs = 1'b1; data_in = 8'($urandom);
    step();
    e = cyc;
    if (adr >= 15'h00F0 && adr <= 15'h00FF) begin
      c = (int'(adr) - 'hF0) >> 2;
      o = int'(adr) & 3;
      case (o)
        0: begin m_armed[c] = 1'b1; m_e0[c] = e; m_sv[c] = 1'b0; m_snap[c] = 0; end
        1: m_thr[c] = int'(d);
        3: if (!d[0] && m_armed[c]) begin m_fz[c] = elapsed(c, e); m_armed[c] = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic do_read(input logic [14:0] adr, input string tag);
    logic [31:0] exp;
    int c, o, v;
    bit win;
    win = (adr >= 15'h00F0 && adr <= 15'h00FF);
    c = 0;
    if (win) begin
      c = (int'(adr) - 'hF0) >> 2;
      o = int'(adr) & 3;
      v = cval(c);
      case (o)
        0: begin
          exp = (v > m_thr[c]) ? 32'hFF : 32'h00;
          if (m_armed[c] && !m_sv[c]) begin m_snap[c] = v; m_sv[c] = 1'b1; end
        end
        1: exp = 32'(m_thr[c]);
        2: exp = 32'(m_snap[c]);
        default: exp = 32'((int'(m_sv[c]) << 2) | ((v == 255) ? 2 : 0) | int'(m_armed[c]));
      endcase
    end else begin
      exp = 32'(rom_m[int'(adr) & 127]);
    end
    adr_in = adr; nrd = 1'b0; ncs = 1'b0; nwr = 1'b1;
    #1;
    check_eq({tag, "_drv"}, 32'(data_drv), 32'd1);
    step();
    step();
    check_eq(tag, 32'(data_out), exp);
    if (win) begin
      check_eq({tag, "_chan"}, 32'(chan), 32'(c));
      check_eq({tag, "_led"}, 32'(led[11:0]), 32'((c << 8) | m_snap[0]));
    end
    nrd = 1'b1; ncs = 1'b1;
    step();
  endtask

  function automatic logic [14:0] rand_rom_adr();
    int a;
    a = $urandom_range(0, 32767);
    if ((a & 'h7FF0) == 'h00F0) a = a ^ 'h100;
    return 15'(a);
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) rom_m[i] = ((i * 37) & 255) ^ 'h5A;
    model_reset();
    n_reset = 1'b0; adr_in = 15'h0; data_in = 8'h0; nrd = 1'b1; nwr = 1'b1; ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out", 32'(data_out), 32'h0);
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_chan", 32'(chan), 32'h0);
    check_eq("rst_drv", 32'(data_drv), 32'h0);
    n_reset = 1'b1;
    step();

    // ROM path and latency
    do_read(15'h0005, "rom5");
    do_read(15'h0100, "rom_above_win");
    do_read(15'h00EF, "rom_below_win");
    bus_write(15'h0005, 8'h99, 2);
    do_read(15'h0005, "rom_not_written");

    // Threshold registers
    bus_write(15'h00F5, 8'h20, 3);
    do_read(15'h00F5, "thr1");
    do_read(15'h00F1, "thr0_rst");

    // Compare on channel 0
    bus_write(15'h00F0, 8'h00, 3);
    wait_cycles('h20);
    do_read(15'h00F0, "cmp_above");
    bus_write(15'h00F1, 8'h40, 2);
    bus_write(15'h00F0, 8'h00, 3);
    wait_cycles('h20);
    do_read(15'h00F0, "cmp_below");

    // Snapshot on channel 2
    bus_write(15'h00F8, 8'h00, 3);
    wait_cycles('h37);
    do_read(15'h00F8, "snap_first");
    wait_cycles('h30);
    do_read(15'h00F8, "snap_second");
    do_read(15'h00FA, "snap_kept");
    do_read(15'h00FB, "stat_snap");

    // Saturation on channel 3, then re-arm
    bus_write(15'h00FD, 8'hFE, 2);
    bus_write(15'h00FC, 8'h00, 3);
    wait_cycles(300);
    do_read(15'h00FF, "stat_sat");
    do_read(15'h00FC, "cmp_sat");
    bus_write(15'h00FC, 8'h00, 2);
    do_read(15'h00FF, "stat_rearm");

    // Disarm freezes channel 2 (re-armed first)
    bus_write(15'h00F8, 8'h00, 1);
    wait_cycles(20);
    bus_write(15'h00FB, 8'h00, 2);
    wait_cycles(30);
    do_read(15'h00F8, "cmp_frozen");
    do_read(15'h00FB, "stat_frozen");

    // Bus direction: write wins over read
    adr_in = 15'h0003; nrd = 1'b0; nwr = 1'b0; ncs = 1'b0;
    #1;
    check_eq("drv_rd_wr", 32'(data_drv), 32'd0);
    nwr = 1'b1;
    #1;
    check_eq("drv_rd", 32'(data_drv), 32'd1);
    nrd = 1'b1; ncs = 1'b1;
    step(); step();

    // Asynchronous reset mid-count on channel 0
    bus_write(15'h00F0, 8'h00, 2);
    do_read(15'h00FF, "pre_rst_stat3");
    adr_in = 15'h0005;
    wait_cycles(10);
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    check_eq("async_rst_data_out", 32'(data_out), 32'h0);
    check_eq("async_rst_chan", 32'(chan), 32'h0);
    check_eq("async_rst_led", 32'(led), 32'h0);
    step();
    n_reset = 1'b1;
    model_reset();
    step();
    do_read(15'h00F3, "post_rst_stat0");
    do_read(15'h00F1, "post_rst_thr0");
    do_read(15'h00F0, "post_rst_cmp0");

    // Reset during a write strobe: nothing is committed
    adr_in = 15'h00F5; data_in = 8'h55; nwr = 1'b0; ncs = 1'b0;
    step(); step();
    n_reset = 1'b0;
    #1;
    nwr = 1'b1; ncs = 1'b1;
    step();
    n_reset = 1'b1;
    model_reset();
    step();
    do_read(15'h00F5, "rst_strobe_thr1");

    // Random traffic against the model
    for (int it = 0; it < 160; it++) begin
      int c, op;
      c  = $urandom_range(0, 3);
      op = $urandom_range(0, 8);
      case (op)
        0: bus_write(15'(('hF0 + 4 * c) + 1), 8'($urandom), $urandom_range(1, 4));
        1: bus_write(15'('hF0 + 4 * c), 8'($urandom), $urandom_range(1, 4));
        2: do_read(15'('hF0 + 4 * c), "rnd_cmp");
        3: do_read(15'(('hF0 + 4 * c) + 2), "rnd_snap");
        4: do_read(15'(('hF0 + 4 * c) + 3), "rnd_stat");
        5: do_read(15'(('hF0 + 4 * c) + 1), "rnd_thr");
        6: bus_write(15'(('hF0 + 4 * c) + 3), 8'($urandom), $urandom_range(1, 3));
        7: begin
          if ($urandom_range(0, 1) == 0) bus_write(rand_rom_adr(), 8'($urandom), 2);
          do_read(rand_rom_adr(), "rnd_rom");
        end
        default: wait_cycles(($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 60));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
